bus_rr_multi: RTL and testbench

//  Parametrised shared system bus: N_MASTERS masters, N_SLAVES slaves, round-robin arbitration.

---
 rtl/bus_rr_multi.sv | 144 ++++++++++++++
 tb/tb_bus_rr_multi.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_rr_multi.sv
// Shared bus: round-robin arbitration across N_MASTERS masters, base/mask decode to N_SLAVES
// slaves, registered read-data return and decode-error reporting.
module bus_rr_multi #(
  parameter int                          DATA_W    = 64,
  parameter int                          ADDR_W    = 16,
  parameter int                          N_MASTERS = 2,
  parameter int                          N_SLAVES  = 2,
  parameter logic [N_SLAVES*ADDR_W-1:0]  S_BASE    = {16'h7000, 16'h0000},
  parameter logic [N_SLAVES*ADDR_W-1:0]  S_MASK    = {16'hFE00, 16'hF800},
  parameter int                          MAX_HOLD  = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_MASTERS-1:0]          m_req,
  input  logic [N_MASTERS-1:0]          m_wr,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
  input  logic [N_MASTERS*DATA_W-1:0]   m_dout,
  output logic [N_MASTERS-1:0]          m_grant,
  output logic [DATA_W-1:0]             m_din,
  output logic                          m_err,
  input  logic [N_SLAVES*DATA_W-1:0]    s_dout,
  output logic [N_SLAVES-1:0]           s_sel,
  output logic [ADDR_W-1:0]             s_addr,
  output logic                          s_wr,
  output logic [DATA_W-1:0]             s_din
);

  localparam int IDX_W  = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HOLD_W'(MAX_HOLD - 1) : '0;

  typedef enum logic {IDLE, OWNED} state_t;

  state_t               state_reg, state_next;
  logic [N_MASTERS-1:0] grant_reg, grant_next;
  logic [IDX_W-1:0]     ptr_reg, ptr_next;
  logic [HOLD_W-1:0]    hold_reg, hold_next;
  logic [N_SLAVES-1:0]  sel_q_reg;
  logic                 err_q_reg;

  logic [IDX_W-1:0]     owner, winner;
  logic                 found, active, others_req, hold_hit, rearb;
  logic [ADDR_W-1:0]    owner_addr;
  logic [N_SLAVES-1:0]  hit, sel;
  logic                 taken;
  logic [DATA_W-1:0]    din;

  always_comb begin
    owner = '0;
    for (int i = 0; i < N_MASTERS; i++)
      if (grant_reg[i]) owner = IDX_W'(i);
  end

  assign active     = (state_reg == OWNED) && m_req[owner];
  assign others_req = |(m_req & ~grant_reg);
  assign hold_hit   = (MAX_HOLD != 0) && (hold_reg == HOLD_LAST) && active;

  // Search starts just above the last winner so every requester is served in turn.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int i = 1; i <= N_MASTERS; i++) begin
      if (!found && m_req[(int'(ptr_reg) + i) % N_MASTERS]) begin
        found  = 1'b1;
        winner = IDX_W'((int'(ptr_reg) + i) % N_MASTERS);
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    ptr_next   = ptr_reg;
    hold_next  = hold_reg;
    rearb      = (state_reg == IDLE) || !active || (hold_hit && others_req);
    if (rearb) begin
      hold_next = '0;
      if (found) begin
        state_next = OWNED;
        grant_next = N_MASTERS'(1) << winner;
        ptr_next   = winner;
      end else begin
        state_next = IDLE;
        grant_next = '0;
      end
    end else if ((MAX_HOLD != 0) && (hold_reg != HOLD_LAST)) begin
      // Saturates so a late competitor preempts the owner immediately.
      hold_next = hold_reg + 1'b1;
    end
  end

  assign owner_addr = m_addr[owner*ADDR_W +: ADDR_W];

  genvar gi;
  generate
    for (gi = 0; gi < N_SLAVES; gi++) begin : g_hit
      assign hit[gi] = (owner_addr & S_MASK[gi*ADDR_W +: ADDR_W]) == S_BASE[gi*ADDR_W +: ADDR_W];
    end
  endgenerate

  // Lowest-index slave wins when windows overlap.
  always_comb begin
    sel   = '0;
    taken = 1'b0;
    for (int k = 0; k < N_SLAVES; k++) begin
      if (active && hit[k] && !taken) sel[k] = 1'b1;
      taken = taken | hit[k];
    end
  end

  assign s_sel  = sel;
  assign s_addr = active ? owner_addr : '0;
  assign s_wr   = active ? m_wr[owner] : 1'b0;
  assign s_din  = active ? m_dout[owner*DATA_W +: DATA_W] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      grant_reg <= '0;
      ptr_reg   <= IDX_W'(N_MASTERS - 1);
      hold_reg  <= '0;
      sel_q_reg <= '0;
      err_q_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      ptr_reg   <= ptr_next;
      hold_reg  <= hold_next;
      sel_q_reg <= sel;
      err_q_reg <= active & ~|hit;
    end
  end

  always_comb begin
    din = '0;
    for (int k = 0; k < N_SLAVES; k++)
      if (sel_q_reg[k]) din = din | s_dout[k*DATA_W +: DATA_W];
  end

  assign m_din   = din;
  assign m_err   = err_q_reg;
  assign m_grant = grant_reg;

endmodule

// File: tb/tb_bus_rr_multi.sv
// Directed bench for bus_rr_multi: a default 2x2 instance and a 3x3 instance with overlapping windows.
module tb_bus_rr_multi;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  int           checks = 0;
  int           failures = 0;

  logic [1:0]   m_req = '0, m_wr = '0, m_grant;
  logic [31:0]  m_addr = '0;
  logic [127:0] m_dout = '0, s_dout = '0;
  logic [63:0]  m_din, s_din;
  logic         m_err, s_wr;
  logic [1:0]   s_sel;
  logic [15:0]  s_addr;

  logic [2:0]   m_req3 = '0, m_wr3 = '0, m_grant3;
  logic [47:0]  m_addr3 = '0;
  logic [191:0] m_dout3 = '0, s_dout3 = '0;
  logic [63:0]  m_din3, s_din3;
  logic         m_err3, s_wr3;
  logic [2:0]   s_sel3;
  logic [15:0]  s_addr3;

  always #5 clk = ~clk;

  bus_rr_multi #(
    .DATA_W(64), .ADDR_W(16), .N_MASTERS(2), .N_SLAVES(2),
    .S_BASE({16'h7000, 16'h0000}), .S_MASK({16'hFE00, 16'hF800}), .MAX_HOLD(8)
  ) u2 (
    .clk(clk), .reset(reset), .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr), .m_dout(m_dout),
    .m_grant(m_grant), .m_din(m_din), .m_err(m_err), .s_dout(s_dout), .s_sel(s_sel),
    .s_addr(s_addr), .s_wr(s_wr), .s_din(s_din)
  );

  bus_rr_multi #(
    .DATA_W(64), .ADDR_W(16), .N_MASTERS(3), .N_SLAVES(3),
    .S_BASE({16'h7000, 16'h7000, 16'h0000}), .S_MASK({16'hFE00, 16'hF000, 16'hF800}), .MAX_HOLD(2)
  ) u3 (
    .clk(clk), .reset(reset), .m_req(m_req3), .m_wr(m_wr3), .m_addr(m_addr3), .m_dout(m_dout3),
    .m_grant(m_grant3), .m_din(m_din3), .m_err(m_err3), .s_dout(s_dout3), .s_sel(s_sel3),
    .s_addr(s_addr3), .s_wr(s_wr3), .s_din(s_din3)
  );

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    m_req = 2'b11;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (m_grant !== 2'b00) begin failures++; $display("FAIL reset_grant cyc=%0d got=%b exp=00", i, m_grant); end
      checks++;
      if (s_sel !== 2'b00) begin failures++; $display("FAIL reset_sel cyc=%0d got=%b exp=00", i, s_sel); end
      checks++;
      if (m_din !== 64'd0) begin failures++; $display("FAIL reset_din cyc=%0d got=%h exp=0", i, m_din); end
    end
    $display("test_reset done");
  endtask

  task automatic test_read();
    reset  = 1'b0;
    m_req  = 2'b01;
    m_wr   = 2'b00;
    m_addr = {16'h0000, 16'h0001};
    s_dout = {64'hAAAA, 64'h1};
    @(posedge clk); #1;
    checks++;
    if (m_grant !== 2'b01) begin failures++; $display("FAIL read_grant got=%b exp=01", m_grant); end
    checks++;
    if (s_sel !== 2'b01) begin failures++; $display("FAIL read_sel got=%b exp=01", s_sel); end
    checks++;
    if (s_wr !== 1'b0) begin failures++; $display("FAIL read_wr got=%b exp=0", s_wr); end
    checks++;
    if (s_addr !== 16'h0001) begin failures++; $display("FAIL read_addr got=%h exp=0001", s_addr); end
    @(posedge clk); #1;
    checks++;
    if (m_din !== 64'h1) begin failures++; $display("FAIL read_din got=%h exp=1", m_din); end
    checks++;
    if (m_err !== 1'b0) begin failures++; $display("FAIL read_err got=%b exp=0", m_err); end
    m_req = 2'b00;
    @(posedge clk); #1;
    checks++;
    if (m_grant !== 2'b00) begin failures++; $display("FAIL read_release got=%b exp=00", m_grant); end
    $display("test_read done");
  endtask

  task automatic test_write_miss();
    do_reset();
    m_req  = 2'b01;
    m_wr   = 2'b01;
    m_addr = {16'h0000, 16'h71AB};
    m_dout = {64'h0, 64'h26};
    @(posedge clk); #1;
    checks++;
    if (s_sel !== 2'b10) begin failures++; $display("FAIL wr_sel got=%b exp=10", s_sel); end
    checks++;
    if (s_wr !== 1'b1) begin failures++; $display("FAIL wr_wr got=%b exp=1", s_wr); end
    checks++;
    if (s_addr !== 16'h71AB) begin failures++; $display("FAIL wr_addr got=%h exp=71AB", s_addr); end
    checks++;
    if (s_din !== 64'h26) begin failures++; $display("FAIL wr_din got=%h exp=26", s_din); end
    @(posedge clk); #1;
    m_addr = {16'h0000, 16'h0800};
    #1;
    checks++;
    if (s_sel !== 2'b00) begin failures++; $display("FAIL miss_sel got=%b exp=00", s_sel); end
    checks++;
    if (m_din !== 64'hAAAA) begin failures++; $display("FAIL wr_return got=%h exp=AAAA", m_din); end
    checks++;
    if (m_err !== 1'b0) begin failures++; $display("FAIL wr_err got=%b exp=0", m_err); end
    @(posedge clk); #1;
    checks++;
    if (m_err !== 1'b1) begin failures++; $display("FAIL miss_err got=%b exp=1", m_err); end
    checks++;
    if (m_din !== 64'd0) begin failures++; $display("FAIL miss_din got=%h exp=0", m_din); end
    m_req = 2'b00;
    @(posedge clk); #1;
    checks++;
    if (m_err !== 1'b0) begin failures++; $display("FAIL miss_pulse got=%b exp=0", m_err); end
    m_wr = 2'b00;
    $display("test_write_miss done");
  endtask

  task automatic test_hold_alternate();
    logic [1:0] exp;
    do_reset();
    m_req  = 2'b11;
    m_addr = {16'h0004, 16'h0002};
    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1;
      exp = (((i / 8) % 2) == 0) ? 2'b01 : 2'b10;
      checks++;
      if (m_grant !== exp) begin failures++; $display("FAIL hold_alt cyc=%0d got=%b exp=%b", i, m_grant, exp); end
    end
    m_req = 2'b00;
    $display("test_hold_alternate done");
  endtask

  task automatic test_owner_drop();
    do_reset();
    m_req  = 2'b01;
    m_addr = {16'h0004, 16'h0002};
    @(posedge clk); #1;
    m_req = 2'b10;
    #1;
    checks++;
    if (m_grant !== 2'b01) begin failures++; $display("FAIL drop_keep got=%b exp=01", m_grant); end
    checks++;
    if (s_sel !== 2'b00) begin failures++; $display("FAIL drop_sel got=%b exp=00", s_sel); end
    @(posedge clk); #1;
    checks++;
    if (m_grant !== 2'b10) begin failures++; $display("FAIL drop_move got=%b exp=10", m_grant); end
    checks++;
    if (s_addr !== 16'h0004) begin failures++; $display("FAIL drop_addr got=%h exp=0004", s_addr); end
    m_req = 2'b00;
    $display("test_owner_drop done");
  endtask

  task automatic test_hold_saturate();
    do_reset();
    m_req = 2'b01;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      checks++;
      if (m_grant !== 2'b01) begin failures++; $display("FAIL sat_keep cyc=%0d got=%b exp=01", i, m_grant); end
    end
    m_req = 2'b11;
    @(posedge clk); #1;
    checks++;
    if (m_grant !== 2'b10) begin failures++; $display("FAIL sat_preempt got=%b exp=10", m_grant); end
    m_req = 2'b00;
    $display("test_hold_saturate done");
  endtask

  task automatic test_three_way();
    logic [2:0] exp_seq [7];
    exp_seq = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100, 3'b001};
    do_reset();
    m_req3  = 3'b111;
    m_addr3 = {16'h7010, 16'h7010, 16'h7010};
    s_dout3 = {64'h3, 64'h2, 64'h1};
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      checks++;
      if (m_grant3 !== exp_seq[i]) begin failures++; $display("FAIL rr3 cyc=%0d got=%b exp=%b", i, m_grant3, exp_seq[i]); end
      if (i == 0) begin
        checks++;
        if (s_sel3 !== 3'b010) begin failures++; $display("FAIL overlap_sel got=%b exp=010", s_sel3); end
      end
      if (i == 1) begin
        checks++;
        if (m_din3 !== 64'h2) begin failures++; $display("FAIL overlap_din got=%h exp=2", m_din3); end
      end
    end
    m_req3 = 3'b000;
    $display("test_three_way done");
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_miss();
    test_hold_alternate();
    test_owner_drop();
    test_hold_saturate();
    test_three_way();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
